// File: rtl/mtime_counter.sv
// 64-bit machine timer with prescaler, split 32-bit write ports and a coherent high-word read snapshot.
// mtime updates one edge after a write or tick; tick is combinational; no backpressure, writes win over counting.
module mtime_counter #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wrl_n,
  input  logic        wrh_n,
  input  logic        rdl_n,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [31:0] mtimel_o,
  output logic [31:0] mtimeh_o,
  output logic        tick
);

  localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic [31:0] snap;
  logic        wr;

  assign wr       = ~wrl_n | ~wrh_n;
  assign tick     = en & wrl_n & wrh_n & (pcnt == PCNT_MAX);
  assign mtimel_o = mtime[31:0];
  assign mtimeh_o = snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= 64'd0;
      pcnt  <= 16'd0;
      snap  <= 32'd0;
    end else begin
      // Snapshot uses the pre-edge high word so it pairs with the low word read this cycle.
      if (!rdl_n) snap <= mtime[63:32];
      if (wr) begin
        if (!wrl_n) mtime[31:0]  <= wdata;
        if (!wrh_n) mtime[63:32] <= wdata;
        pcnt <= 16'd0;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
        pcnt  <= 16'd0;
      end else if (en) begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mtime_counter.sv
// Bench driving a PRESCALE=4 and a PRESCALE=1 instance with shared stimulus against a reference model.
module tb_mtime_counter;

  logic        clk = 1'b0;
  logic        rst, en, wrl_n, wrh_n, rdl_n;
  logic [31:0] wdata;
  logic [63:0] mtime4, mtime1;
  logic [31:0] ml4, mh4, ml1, mh1;
  logic        tick4, tick1;

  always #5 clk = ~clk;

  mtime_counter #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .wrl_n(wrl_n), .wrh_n(wrh_n), .rdl_n(rdl_n),
    .wdata(wdata), .mtime(mtime4), .mtimel_o(ml4), .mtimeh_o(mh4), .tick(tick4)
  );

  mtime_counter #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .wrl_n(wrl_n), .wrh_n(wrh_n), .rdl_n(rdl_n),
    .wdata(wdata), .mtime(mtime1), .mtimel_o(ml1), .mtimeh_o(mh1), .tick(tick1)
  );

  int runs  = 0;
  int fails = 0;

  // Reference model: index 0 is the PRESCALE=4 instance, index 1 the PRESCALE=1 instance.
  int          period [2] = '{4, 1};
  logic [63:0] m_time [2] = '{64'd0, 64'd0};
  int          m_cnt  [2] = '{0, 0};
  logic [31:0] m_snap [2] = '{32'd0, 32'd0};
  bit          m_tick [2];
  bit          o_tick [2];

  task automatic step(input bit r, input bit e, input bit wl, input bit wh, input bit rl,
                      input logic [31:0] wd);
    bit wr;
    rst = r; en = e; wrl_n = wl; wrh_n = wh; rdl_n = rl; wdata = wd;
    #1;
    o_tick[0] = tick4;
    o_tick[1] = tick1;
    wr = !wl || !wh;
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = e && !wr && (m_cnt[i] == period[i] - 1);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_time[i] = 64'd0; m_cnt[i] = 0; m_snap[i] = 32'd0;
      end else begin
        if (!rl) m_snap[i] = m_time[i][63:32];
        if (wr) begin
          if (!wl) m_time[i][31:0]  = wd;
          if (!wh) m_time[i][63:32] = wd;
          m_cnt[i] = 0;
        end else if (e) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == period[i]) begin
            m_cnt[i]  = 0;
            m_time[i] = m_time[i] + 64'd1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 0, 0, 0, 32'h1234_5678);
    step(1, 1, 0, 0, 0, 32'hDEAD_BEEF);
    runs++; if (mtime4 !== 64'd0) begin fails++; $display("FAIL reset_mtime4: got %h want 0", mtime4); end
    runs++; if (ml4 !== 32'd0) begin fails++; $display("FAIL reset_mtimel4: got %h want 0", ml4); end
    runs++; if (mh4 !== 32'd0) begin fails++; $display("FAIL reset_mtimeh4: got %h want 0", mh4); end
    runs++; if (mtime1 !== 64'd0) begin fails++; $display("FAIL reset_mtime1: got %h want 0", mtime1); end
    step(0, 1, 1, 1, 1, 32'd0);
    runs++; if (o_tick[0] !== 1'b0) begin fails++; $display("FAIL reset_tick4: got %b want 0", o_tick[0]); end
  endtask

  task automatic test_prescale();
    step(1, 0, 1, 1, 1, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 1, 1, 1, 32'd0);
      runs++;
      if (o_tick[0] !== (k % 4 == 0)) begin
        fails++; $display("FAIL prescale_tick cycle %0d: got %b want %b", k, o_tick[0], (k % 4 == 0));
      end
    end
    runs++; if (mtime4 !== 64'd3) begin fails++; $display("FAIL prescale_mtime4: got %h want 3", mtime4); end
    runs++; if (mtime1 !== 64'd12) begin fails++; $display("FAIL prescale_mtime1: got %h want 12", mtime1); end
  endtask

  task automatic test_carry();
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    step(0, 0, 1, 0, 1, 32'h0000_0001);
    runs++; if (mtime1 !== 64'h1_FFFF_FFFF) begin fails++; $display("FAIL carry_load: got %h want 1ffffffff", mtime1); end
    step(0, 1, 1, 1, 1, 32'd0);
    runs++; if (mtime1 !== 64'h2_0000_0000) begin fails++; $display("FAIL carry_inc: got %h want 200000000", mtime1); end
    runs++; if (mtime4 !== 64'h1_FFFF_FFFF) begin fails++; $display("FAIL carry_p4_hold: got %h want 1ffffffff", mtime4); end
  endtask

  task automatic test_wrap();
    logic [31:0] snap_before;
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    snap_before = m_snap[1];
    runs++; if (mtime1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL wrap_load: got %h want all ones", mtime1); end
    step(0, 1, 1, 1, 1, 32'd0);
    runs++; if (mtime1 !== 64'd0) begin fails++; $display("FAIL wrap_mtime: got %h want 0", mtime1); end
    runs++; if (ml1 !== 32'd0) begin fails++; $display("FAIL wrap_mtimel: got %h want 0", ml1); end
    runs++; if (mh1 !== snap_before) begin fails++; $display("FAIL wrap_snapshot: got %h want %h", mh1, snap_before); end
  endtask

  task automatic test_write_priority();
    logic [31:0] lo;
    lo = 32'($urandom_range(32'hFFFF_0000, 32'h0000_0100));
    step(1, 0, 1, 1, 1, 32'd0);
    step(0, 0, 0, 1, 1, lo);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 1, 32'd0);
    step(0, 1, 1, 0, 1, 32'h5);
    runs++; if (o_tick[0] !== 1'b0) begin fails++; $display("FAIL wprio_tick: got %b want 0", o_tick[0]); end
    runs++; if (mtime4 !== {32'h5, lo}) begin fails++; $display("FAIL wprio_mtime: got %h want %h", mtime4, {32'h5, lo}); end
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 1, 1, 1, 32'd0);
      runs++;
      if (o_tick[0] !== (k == 4)) begin fails++; $display("FAIL wprio_pcnt_clear cycle %0d: got %b want %b", k, o_tick[0], (k == 4)); end
    end
    runs++; if (mtime4 !== {32'h5, lo + 32'd1}) begin fails++; $display("FAIL wprio_after: got %h want %h", mtime4, {32'h5, lo + 32'd1}); end
  endtask

  task automatic test_snapshot();
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF);
    step(0, 0, 1, 0, 1, 32'h7);
    step(0, 1, 1, 1, 0, 32'd0);
    runs++; if (o_tick[1] !== 1'b1) begin fails++; $display("FAIL snap_tick: got %b want 1", o_tick[1]); end
    runs++; if (mh1 !== 32'h7) begin fails++; $display("FAIL snap_high: got %h want 7", mh1); end
    runs++; if (mtime1 !== 64'h8_0000_0000) begin fails++; $display("FAIL snap_mtime: got %h want 800000000", mtime1); end
    step(0, 0, 1, 0, 1, 32'hAAAA_0000);
    runs++; if (mh1 !== 32'h7) begin fails++; $display("FAIL snap_hold: got %h want 7", mh1); end
  endtask

  task automatic test_freeze_reset();
    step(1, 0, 1, 1, 1, 32'd0);
    step(0, 0, 0, 0, 1, 32'h0000_0042);
    step(0, 1, 1, 1, 1, 32'd0);
    step(0, 1, 1, 1, 1, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 1, 1, 32'd0);
      runs++;
      if (mtime4 !== 64'h42_0000_0042 || o_tick[0] !== 1'b0) begin
        fails++; $display("FAIL freeze cycle %0d: got %h/%b want 4200000042/0", k, mtime4, o_tick[0]);
      end
    end
    step(0, 1, 1, 1, 1, 32'd0);
    runs++; if (o_tick[0] !== 1'b0) begin fails++; $display("FAIL freeze_pcnt2: got %b want 0", o_tick[0]); end
    step(1, 1, 1, 1, 0, 32'd0);
    runs++; if (o_tick[0] !== 1'b1) begin fails++; $display("FAIL freeze_pcnt3: got %b want 1", o_tick[0]); end
    runs++; if (mtime4 !== 64'd0 || mh4 !== 32'd0) begin fails++; $display("FAIL midreset: got %h/%h want 0/0", mtime4, mh4); end
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 1, 1, 1, 32'd0);
      runs++;
      if (o_tick[0] !== (k == 4)) begin fails++; $display("FAIL resume cycle %0d: got %b want %b", k, o_tick[0], (k == 4)); end
    end
    runs++; if (mtime4 !== 64'd1) begin fails++; $display("FAIL resume_mtime: got %h want 1", mtime4); end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    bit r, e, wl, wh, rl;
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(59, 0) == 0);
      e  = ($urandom_range(3, 0) != 0);
      wl = ($urandom_range(9, 0) != 0);
      wh = ($urandom_range(9, 0) != 0);
      rl = ($urandom_range(4, 0) != 0);
      case ($urandom_range(3, 0))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'hFFFF_FFFD;
        default: wd = $urandom;
      endcase
      step(r, e, wl, wh, rl, wd);
      for (int i = 0; i < 2; i++) begin
        runs++;
        if (o_tick[i] !== m_tick[i]) begin fails++; $display("FAIL rnd_tick[%0d] step %0d: got %b want %b", i, n, o_tick[i], m_tick[i]); end
        runs++;
        if ((i == 0 ? mtime4 : mtime1) !== m_time[i]) begin
          fails++; $display("FAIL rnd_mtime[%0d] step %0d: got %h want %h", i, n, (i == 0 ? mtime4 : mtime1), m_time[i]);
        end
        runs++;
        if ((i == 0 ? ml4 : ml1) !== m_time[i][31:0]) begin
          fails++; $display("FAIL rnd_mtimel[%0d] step %0d: got %h want %h", i, n, (i == 0 ? ml4 : ml1), m_time[i][31:0]);
        end
        runs++;
        if ((i == 0 ? mh4 : mh1) !== m_snap[i]) begin
          fails++; $display("FAIL rnd_mtimeh[%0d] step %0d: got %h want %h", i, n, (i == 0 ? mh4 : mh1), m_snap[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wrl_n = 1'b1; wrh_n = 1'b1; rdl_n = 1'b1; wdata = 32'd0;
    test_reset();
    test_prescale();
    test_carry();
    test_wrap();
    test_write_priority();
    test_snapshot();
    test_freeze_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule

// File: doc/mtime_counter.md
MTIME_COUNTER -- requirements
Module: mtime_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en  input  1  count enable; 0 freezes the prescaler and mtime.
REQ-005 SHALL have port wrl_n  input  1  active-low write strobe for mtime[31:0].
REQ-006 SHALL have port wrh_n  input  1  active-low write strobe for mtime[63:32].
REQ-007 SHALL have port rdl_n  input  1  active-low low-word read strobe; captures the high-word snapshot.
REQ-008 SHALL have port wdata  input  32  write data for either half.
REQ-009 SHALL have port mtime  output  64  current counter value, registered; drives the downstream compare stage directly.
REQ-010 SHALL have port mtimel_o  output  32  readback of mtime[31:0], equal to mtime[31:0].
REQ-011 SHALL have port mtimeh_o  output  32  readback of the high-word snapshot register.
REQ-012 SHALL have port tick  output  1  combinational; high in each cycle whose closing edge increments mtime.

Function
REQ-013 SHALL hold a prescaler pcnt counting 0..PRESCALE-1, with width sufficient for 65535.
REQ-014 SHALL define tick = en & wrl_n & wrh_n & (pcnt == PRESCALE-1).
REQ-015 SHALL, on an edge with tick=1, set mtime <= mtime + 1 (full 64-bit, carry across the 32-bit boundary in the same edge) and pcnt <= 0.
REQ-016 SHALL, on an edge with en=1, no write and tick=0, set pcnt <= pcnt + 1 and hold mtime.
REQ-017 SHALL, on an edge with en=0 and no write, hold pcnt and mtime.
REQ-018 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 with no other side effect.
REQ-019 SHALL, on an edge with wrl_n=0, load mtime[31:0] <= wdata; mtime[63:32] SHALL hold unless wrh_n=0.
REQ-020 SHALL, on an edge with wrh_n=0, load mtime[63:32] <= wdata; mtime[31:0] SHALL hold unless wrl_n=0.
REQ-021 SHALL, when wrl_n=0 and wrh_n=0 on the same edge, load both halves with wdata.
REQ-022 SHALL, on any write edge, suppress the increment regardless of en or pcnt, and clear pcnt to 0.
REQ-023 SHALL, on an edge with rdl_n=0, load snapshot <= mtime[63:32], using the register value before that edge's update.
REQ-024 SHALL hold the snapshot while rdl_n=1; writes and increments SHALL NOT alter it.
REQ-025 SHALL, for rdl_n=0 together with a write or increment on the same edge, capture the pre-edge high word (REQ-023), so a later read of mtimeh_o pairs coherently with the low word read in that cycle.
REQ-026 SHALL, for PRESCALE=1, hold pcnt at 0 and assert tick in every en=1 cycle without a write.
REQ-027 SHALL make mtime visible to downstream logic one edge after a write or increment, with no further latency.

Reset
REQ-028 SHALL, on an edge with rst=1, clear mtime, pcnt and snapshot to 0; rst SHALL override writes, rdl_n and en.
REQ-029 SHALL, as a consequence of REQ-028, show mtime=0, mtimel_o=0, mtimeh_o=0 and tick=0 in the cycle after reset while PRESCALE>1.
REQ-030 SHALL resume counting from pcnt=0 on the first en=1 cycle after rst deasserts, including when reset is asserted mid-prescale.

Verification
REQ-031 SHALL cover: PRESCALE=4, en=1 for 12 cycles after reset -> tick high on cycles 4, 8, 12; mtime=3.
REQ-032 SHALL cover: PRESCALE=1, wrl_n=0 wdata=0xFFFF_FFFF, then wrh_n=0 wdata=0x0000_0001, then en=1 for one edge -> mtime 0x0000_0001_FFFF_FFFF then 0x0000_0002_0000_0000.
REQ-033 SHALL cover: both halves written with 0xFFFF_FFFF, PRESCALE=1, en=1 for one edge -> mtime=0, no other output change.
REQ-034 SHALL cover: PRESCALE=4, pcnt=3, en=1, wrh_n=0 wdata=0x5 on the same edge -> no increment, mtime[63:32]=5, low word unchanged, pcnt=0.
REQ-035 SHALL cover: mtime=0x0000_0007_FFFF_FFFF, tick=1 and rdl_n=0 on the same edge -> mtimeh_o=7 while mtime=0x0000_0008_0000_0000.
REQ-036 SHALL cover: PRESCALE=4, en=0 held for 10 cycles at pcnt=2, then rst=1 for one edge -> pcnt and mtime frozen during en=0, then all state 0.
